// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller.
package seg_pkg;

  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned MAX_DIGITS      = 8;
  localparam int unsigned NUM_DIGITS_DEF  = 8;
  localparam int unsigned REFRESH_DIV_DEF = 100000;

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bus of the scan controller: load strobe, display word, digit enables and scan outputs.
interface seg_scan_ctrl_if
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF
);

  logic                          load;
  logic [DIGIT_W*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]         dp_in;
  logic [NUM_DIGITS-1:0]         digit_en;
  logic [NUM_DIGITS-1:0]         anode;
  logic [DIGIT_W-1:0]            hex;
  logic                          dp;
  logic                          frame_done;

  modport master (
    output load, data_in, dp_in, digit_en,
    input  anode, hex, dp, frame_done
  );

  modport slave (
    input  load, data_in, dp_in, digit_en,
    output anode, hex, dp, frame_done
  );

endinterface

// File: rtl/seg_refresh_tick.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and raises tick_o for the cycle the count sits at its top value.
module seg_refresh_tick #(
  parameter int unsigned REFRESH_DIV = seg_pkg::REFRESH_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
  end

  // tick is registered from the next count so it aligns with cnt_q == CNT_MAX
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= (REFRESH_DIV == 1);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_MAX);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with tear-free display update.
// Optional `LEAD_ZERO_BLANK_EN: blank digits above the highest nonzero nibble.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = NUM_DIGITS_DEF,
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic            clk,
  input  logic            reset,
  seg_scan_ctrl_if.slave  bus
);

  localparam int unsigned WORD_W = DIGIT_W * NUM_DIGITS;
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = ANODE_OFF[NUM_DIGITS-1:0];

  logic                  tick;
  logic                  wrap_c;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_W-1:0]     shadow_q, shadow_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] eligible_c;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [DIGIT_W-1:0]    hex_q, hex_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  seg_refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  assign wrap_c = tick && (idx_q == IDX_LAST);

`ifdef LEAD_ZERO_BLANK_EN
  // digit i is eligible when any nibble at or above i is nonzero; digit 0 always is
  always_comb begin
    logic seen;
    seen       = 1'b0;
    eligible_c = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_q[i*DIGIT_W +: DIGIT_W] != '0) seen = 1'b1;
      eligible_c[i] = seen;
    end
    eligible_c[0] = 1'b1;
  end
`else
  assign eligible_c = '1;
`endif

  // scan index, shadow capture and frame-boundary display swap
  always_comb begin
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;
    if (tick) idx_d = wrap_c ? '0 : idx_q + IDX_W'(1);
    if (wrap_c) begin
      if (bus.load) begin
        disp_d    = bus.data_in;
        disp_dp_d = bus.dp_in;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
      end
      pending_d = 1'b0;
    end else if (bus.load) begin
      shadow_d    = bus.data_in;
      shadow_dp_d = bus.dp_in;
      pending_d   = 1'b1;
    end
  end

  always_comb begin
    anode_d = ANODES_OFF;
    if (bus.digit_en[idx_q] && eligible_c[idx_q]) anode_d[idx_q] = 1'b0;
    hex_d        = disp_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
    dp_d         = ~disp_dp_q[idx_q];
    frame_done_d = wrap_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      anode_q      <= ANODES_OFF;
      hex_q        <= '0;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      anode_q      <= anode_d;
      hex_q        <= hex_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.anode      = anode_q;
  assign bus.hex        = hex_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (NUM_DIGITS=8, REFRESH_DIV=4).
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   pos = 0;
  int   cyc = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(8)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (8),
    .REFRESH_DIV (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // advance to the negedge where frame_done is high; pos=0 marks that cycle
  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (bus.frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL frame_wait timeout actual=%b expected=1", bus.frame_done);
    end
    pos = 0;
  endtask

  // move to the middle of digit k's output slot within the current frame
  task automatic goto_digit(input int k);
    int tgt = 2 + 4 * k;
    while (pos < tgt) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic pulse_load(input logic [31:0] d, input logic [7:0] p);
    bus.load = 1'b1; bus.data_in = d; bus.dp_in = p;
    @(negedge clk);
    pos++;
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.digit_en = 8'hFF;
    repeat (3) @(negedge clk);
    checks++; if (bus.anode !== 8'hFF) begin failures++; $display("FAIL reset_anode actual=%h expected=ff", bus.anode); end
    checks++; if (bus.hex !== 4'h0) begin failures++; $display("FAIL reset_hex actual=%h expected=0", bus.hex); end
    checks++; if (bus.dp !== 1'b1) begin failures++; $display("FAIL reset_dp actual=%b expected=1", bus.dp); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd actual=%b expected=0", bus.frame_done); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.anode !== 8'hFE) begin failures++; $display("FAIL first_slot_anode actual=%h expected=fe", bus.anode); end
    repeat (3) @(negedge clk);
    checks++; if (bus.anode !== 8'hFE) begin failures++; $display("FAIL pre_tick_anode actual=%h expected=fe", bus.anode); end
    @(negedge clk);
    checks++; if (bus.anode !== 8'hFD) begin failures++; $display("FAIL first_tick_anode actual=%h expected=fd", bus.anode); end
  endtask

  task automatic test_scan();
    int c1, c2;
    pulse_load(32'h1234_ABCD, 8'h81);
    wait_frame();
    c1 = cyc;
    @(negedge clk); pos++;
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL fd_width actual=%b expected=0", bus.frame_done); end
    wait_frame();
    c2 = cyc;
    checks++; if (c2 - c1 != 32) begin failures++; $display("FAIL fd_period actual=%0d expected=32", c2 - c1); end
    goto_digit(0);
    checks++; if (bus.hex !== 4'hD) begin failures++; $display("FAIL d0_hex actual=%h expected=d", bus.hex); end
    checks++; if (bus.anode !== 8'hFE) begin failures++; $display("FAIL d0_anode actual=%h expected=fe", bus.anode); end
    checks++; if (bus.dp !== 1'b0) begin failures++; $display("FAIL d0_dp actual=%b expected=0", bus.dp); end
    goto_digit(1);
    checks++; if (bus.hex !== 4'hC) begin failures++; $display("FAIL d1_hex actual=%h expected=c", bus.hex); end
    checks++; if (bus.dp !== 1'b1) begin failures++; $display("FAIL d1_dp actual=%b expected=1", bus.dp); end
    goto_digit(7);
    checks++; if (bus.hex !== 4'h1) begin failures++; $display("FAIL d7_hex actual=%h expected=1", bus.hex); end
    checks++; if (bus.anode !== 8'h7F) begin failures++; $display("FAIL d7_anode actual=%h expected=7f", bus.anode); end
    checks++; if (bus.dp !== 1'b0) begin failures++; $display("FAIL d7_dp actual=%b expected=0", bus.dp); end
  endtask

  task automatic test_midframe_load();
    wait_frame();
    goto_digit(3);
    pulse_load(32'h0000_0042, 8'h00);
    goto_digit(5);
    checks++; if (bus.hex !== 4'h3) begin failures++; $display("FAIL mid_old_d5 actual=%h expected=3", bus.hex); end
    checks++; if (bus.anode !== 8'hDF) begin failures++; $display("FAIL mid_old_anode actual=%h expected=df", bus.anode); end
    goto_digit(7);
    checks++; if (bus.hex !== 4'h1) begin failures++; $display("FAIL mid_old_d7 actual=%h expected=1", bus.hex); end
    wait_frame();
    goto_digit(0);
    checks++; if (bus.hex !== 4'h2) begin failures++; $display("FAIL mid_new_d0 actual=%h expected=2", bus.hex); end
    checks++; if (bus.dp !== 1'b1) begin failures++; $display("FAIL mid_new_dp actual=%b expected=1", bus.dp); end
    goto_digit(1);
    checks++; if (bus.hex !== 4'h4) begin failures++; $display("FAIL mid_new_d1 actual=%h expected=4", bus.hex); end
    goto_digit(2);
    checks++; if (bus.hex !== 4'h0) begin failures++; $display("FAIL mid_new_d2 actual=%h expected=0", bus.hex); end
  endtask

  task automatic test_load_at_wrap();
    wait_frame();
    repeat (31) @(negedge clk);
    pos = 31;
    bus.load = 1'b1; bus.data_in = 32'h5555_5555; bus.dp_in = 8'h00;
    @(negedge clk);
    bus.load = 1'b0;
    pos = 0;
    checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL wrap_fd actual=%b expected=1", bus.frame_done); end
    goto_digit(0);
    checks++; if (bus.hex !== 4'h5) begin failures++; $display("FAIL wrap_d0 actual=%h expected=5", bus.hex); end
    checks++; if (bus.anode !== 8'hFE) begin failures++; $display("FAIL wrap_anode actual=%h expected=fe", bus.anode); end
    goto_digit(4);
    checks++; if (bus.hex !== 4'h5) begin failures++; $display("FAIL wrap_d4 actual=%h expected=5", bus.hex); end
  endtask

  task automatic test_digit_en();
    wait_frame();
    goto_digit(2);
    pulse_load(32'h8765_4321, 8'h00);
    wait_frame();
    bus.digit_en = 8'h0F;
    goto_digit(2);
    checks++; if (bus.anode !== 8'hFB) begin failures++; $display("FAIL en_d2_anode actual=%h expected=fb", bus.anode); end
    checks++; if (bus.hex !== 4'h3) begin failures++; $display("FAIL en_d2_hex actual=%h expected=3", bus.hex); end
    goto_digit(6);
    checks++; if (bus.anode !== 8'hFF) begin failures++; $display("FAIL en_d6_anode actual=%h expected=ff", bus.anode); end
    checks++; if (bus.hex !== 4'h7) begin failures++; $display("FAIL en_d6_hex actual=%h expected=7", bus.hex); end
    goto_digit(7);
    checks++; if (bus.anode !== 8'hFF) begin failures++; $display("FAIL en_d7_anode actual=%h expected=ff", bus.anode); end
    checks++; if (bus.hex !== 4'h8) begin failures++; $display("FAIL en_d7_hex actual=%h expected=8", bus.hex); end
    bus.digit_en = 8'hFF;
  endtask

  task automatic test_lead_zero();
    wait_frame();
    goto_digit(1);
    pulse_load(32'h0000_0300, 8'h00);
    wait_frame();
    goto_digit(0);
    checks++; if (bus.anode !== 8'hFE) begin failures++; $display("FAIL lz_d0_anode actual=%h expected=fe", bus.anode); end
    goto_digit(2);
    checks++; if (bus.anode !== 8'hFB || bus.hex !== 4'h3) begin failures++; $display("FAIL lz_d2 actual=%h/%h expected=fb/3", bus.anode, bus.hex); end
    goto_digit(3);
`ifdef LEAD_ZERO_BLANK_EN
    checks++; if (bus.anode !== 8'hFF) begin failures++; $display("FAIL lz_d3_anode actual=%h expected=ff", bus.anode); end
    pulse_load(32'h0000_0000, 8'h00);
    wait_frame();
    goto_digit(0);
    checks++; if (bus.anode !== 8'hFE || bus.hex !== 4'h0) begin failures++; $display("FAIL lz_zero_d0 actual=%h/%h expected=fe/0", bus.anode, bus.hex); end
    goto_digit(1);
    checks++; if (bus.anode !== 8'hFF) begin failures++; $display("FAIL lz_zero_d1 actual=%h expected=ff", bus.anode); end
`else
    checks++; if (bus.anode !== 8'hF7 || bus.hex !== 4'h0) begin failures++; $display("FAIL nolz_d3 actual=%h/%h expected=f7/0", bus.anode, bus.hex); end
    goto_digit(7);
    checks++; if (bus.anode !== 8'h7F) begin failures++; $display("FAIL nolz_d7 actual=%h expected=7f", bus.anode); end
`endif
  endtask

  task automatic test_reset_midframe();
    wait_frame();
    goto_digit(3);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.anode !== 8'hFF) begin failures++; $display("FAIL rst_mid_anode actual=%h expected=ff", bus.anode); end
    checks++; if (bus.hex !== 4'h0 || bus.dp !== 1'b1 || bus.frame_done !== 1'b0) begin
      failures++; $display("FAIL rst_mid_outs actual=%h/%b/%b expected=0/1/0", bus.hex, bus.dp, bus.frame_done);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_frame();
    goto_digit(2);
    checks++; if (bus.hex !== 4'h0 || bus.dp !== 1'b1) begin failures++; $display("FAIL rst_cleared actual=%h/%b expected=0/1", bus.hex, bus.dp); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe_load();
    test_load_at_wrap();
    test_digit_en();
    test_lead_zero();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
